// File: rtl/rf_wport_arbiter.sv
// Shares the register-file write port between WB, the MDU and an optional post-reset clear.
// Define RF_WPORT_REG_CLEAR_EN to compile in the r1..r31 zeroing sequence and busy flag.
module rf_wport_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_req,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        mdu_req,
  input  logic [4:0]  mdu_addr,
  input  logic [31:0] mdu_data,
  output logic        mdu_ack,
  output logic        pipe_stall,
  output logic        rf_wr,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_din,
  output logic        busy
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic        rf_wr_q, rf_wr_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_din_q, rf_din_d;
  logic        mdu_ack_q, mdu_ack_d;
  logic [3:0]  wait_q, wait_d;
  logic        in_clear;
  logic [4:0]  clr_addr;
  logic        mdu_live, starve, grant_mdu, grant_wb;

`ifdef RF_WPORT_REG_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  state_t      state_q, state_d;
  logic [4:0]  clr_idx_q, clr_idx_d;
  logic        busy_q, busy_d;

  assign in_clear = (state_q == ST_CLEAR);
  assign clr_addr = clr_idx_q;
  assign busy     = busy_q;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    // busy trails the state by a cycle so it covers the r31 write on rf_*
    busy_d    = in_clear;
    if (in_clear) begin
      clr_idx_d = clr_idx_q + 5'd1;
      if (clr_idx_q == 5'd31) state_d = ST_RUN;
    end
  end
`else
  assign in_clear = 1'b0;
  assign clr_addr = 5'd0;
  assign busy     = 1'b0;
`endif

  always_comb begin
    // A request is masked during its own ack cycle so one handshake writes once
    mdu_live   = mdu_req & ~mdu_ack_q;
    starve     = (wait_q == STARVE_LIM) & mdu_live;
    pipe_stall = in_clear | starve;

    grant_mdu = 1'b0;
    grant_wb  = 1'b0;
    if (!in_clear) begin
      if (starve)        grant_mdu = 1'b1;
      else if (wb_req)   grant_wb  = 1'b1;
      else if (mdu_live) grant_mdu = 1'b1;
    end

    rf_wr_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_din_d   = rf_din_q;
    if (in_clear) begin
      rf_wr_d    = 1'b1;
      rf_waddr_d = clr_addr;
      rf_din_d   = 32'd0;
    end else if (grant_mdu) begin
      rf_wr_d    = |mdu_addr;
      rf_waddr_d = mdu_addr;
      rf_din_d   = mdu_data;
    end else if (grant_wb) begin
      rf_wr_d    = |wb_addr;
      rf_waddr_d = wb_addr;
      rf_din_d   = wb_data;
    end

    mdu_ack_d = grant_mdu;

    if (!mdu_req || grant_mdu || in_clear) wait_d = 4'd0;
    else if (mdu_live && wait_q != STARVE_LIM) wait_d = wait_q + 4'd1;
    else wait_d = wait_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_din_q   <= 32'd0;
      mdu_ack_q  <= 1'b0;
      wait_q     <= 4'd0;
`ifdef RF_WPORT_REG_CLEAR_EN
      state_q    <= ST_CLEAR;
      clr_idx_q  <= 5'd1;
      busy_q     <= 1'b1;
`endif
    end else begin
      rf_wr_q    <= rf_wr_d;
      rf_waddr_q <= rf_waddr_d;
      rf_din_q   <= rf_din_d;
      mdu_ack_q  <= mdu_ack_d;
      wait_q     <= wait_d;
`ifdef RF_WPORT_REG_CLEAR_EN
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      busy_q     <= busy_d;
`endif
    end
  end

  assign rf_wr    = rf_wr_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_din   = rf_din_q;
  assign mdu_ack  = mdu_ack_q;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter; the clear-sequence steps run when RF_WPORT_REG_CLEAR_EN is defined.
module tb_rf_wport_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_req;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mdu_req;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_ack;
  logic        pipe_stall;
  logic        rf_wr;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_din;
  logic        busy;

  int checks = 0;
  int passed = 0;
  logic [31:0] regs [32];

  rf_wport_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data),
    .mdu_req(mdu_req), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
    .mdu_ack(mdu_ack), .pipe_stall(pipe_stall),
    .rf_wr(rf_wr), .rf_waddr(rf_waddr), .rf_din(rf_din), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register-file model committing whatever the arbiter issues
  always @(posedge clk) if (rf_wr) regs[rf_waddr] <= rf_din;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
      $display("check %-14s observed=%h expected=%h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rf(input string tag, input logic wr, input logic [4:0] a, input logic [31:0] d,
                        input logic ack);
    check({tag, "_wr"}, 32'(rf_wr), 32'(wr));
    if (wr) begin
      check({tag, "_addr"}, 32'(rf_waddr), 32'(a));
      check({tag, "_din"}, rf_din, d);
    end
    check({tag, "_ack"}, 32'(mdu_ack), 32'(ack));
  endtask

  initial begin
    rst = 1'b1; wb_req = 1'b0; wb_addr = '0; wb_data = '0;
    mdu_req = 1'b0; mdu_addr = '0; mdu_data = '0;
    for (int i = 0; i < 32; i++) regs[i] = 32'hFFFF_FFFF;
    cyc(); cyc();
    chk_rf("reset", 1'b0, 5'd0, 32'd0, 1'b0);
    check("reset_waddr", 32'(rf_waddr), 32'd0);
    check("reset_din", rf_din, 32'd0);
`ifdef RF_WPORT_REG_CLEAR_EN
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_stall", 32'(pipe_stall), 32'd1);
    // WB held throughout the clear must be ignored until RUN
    rst = 1'b0; wb_req = 1'b1; wb_addr = 5'd3; wb_data = 32'hAA;
    for (int i = 1; i <= 31; i++) begin
      cyc();
      check("clr_wr", 32'(rf_wr), 32'd1);
      check("clr_addr", 32'(rf_waddr), 32'(i));
      check("clr_din", rf_din, 32'd0);
      check("clr_busy", 32'(busy), 32'd1);
    end
    cyc();
    check("clr_busy_fall", 32'(busy), 32'd0);
    chk_rf("first_wb", 1'b1, 5'd3, 32'hAA, 1'b0);
    wb_req = 1'b0;
    cyc();
    check("clr_regs_r31", regs[31], 32'd0);
`else
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_stall", 32'(pipe_stall), 32'd0);
    rst = 1'b0;
    cyc();
`endif
    // WB only
    wb_req = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    cyc();
    chk_rf("wb_only", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    wb_req = 1'b0;

    // Idle MDU, request held through the ack cycle
    mdu_req = 1'b1; mdu_addr = 5'd9; mdu_data = 32'h12345678;
    #1 check("mdu_idle_stall", 32'(pipe_stall), 32'd0);
    cyc();
    chk_rf("mdu_idle", 1'b1, 5'd9, 32'h12345678, 1'b1);
    cyc();
    chk_rf("mdu_nodup", 1'b0, 5'd0, 32'd0, 1'b0);
    mdu_req = 1'b0;
    cyc();

    // Starvation: continuous WB traffic, MDU forced in after 4 waiting cycles
    wb_req = 1'b1; wb_addr = 5'd10; wb_data = 32'h100;
    mdu_req = 1'b1; mdu_addr = 5'd11; mdu_data = 32'h55;
    #1 check("stv_stall_c0", 32'(pipe_stall), 32'd0);
    cyc(); chk_rf("stv_c1", 1'b1, 5'd10, 32'h100, 1'b0);
    wb_data = 32'h101; #1 check("stv_stall_c1", 32'(pipe_stall), 32'd0);
    cyc(); chk_rf("stv_c2", 1'b1, 5'd10, 32'h101, 1'b0);
    wb_data = 32'h102;
    cyc(); chk_rf("stv_c3", 1'b1, 5'd10, 32'h102, 1'b0);
    wb_data = 32'h103; #1 check("stv_stall_c3", 32'(pipe_stall), 32'd0);
    cyc(); chk_rf("stv_c4", 1'b1, 5'd10, 32'h103, 1'b0);
    wb_data = 32'h104; #1 check("stv_stall_c4", 32'(pipe_stall), 32'd1);
    cyc(); chk_rf("stv_mdu_c5", 1'b1, 5'd11, 32'h55, 1'b1);
    mdu_req = 1'b0; #1 check("stv_stall_c5", 32'(pipe_stall), 32'd0);
    cyc(); chk_rf("stv_wb_c6", 1'b1, 5'd10, 32'h104, 1'b0);
    wb_req = 1'b0;
    cyc();
    check("stv_regs_r10", regs[10], 32'h104);
    check("stv_regs_r11", regs[11], 32'h55);

    // MDU write to r0: acknowledged but no register write
    mdu_req = 1'b1; mdu_addr = 5'd0; mdu_data = 32'h77;
    cyc();
    chk_rf("mdu_r0", 1'b0, 5'd0, 32'd0, 1'b1);
    mdu_req = 1'b0;
    cyc();

    // WB/MDU collision on r7: WB then MDU
    wb_req = 1'b1; wb_addr = 5'd7; wb_data = 32'h1;
    mdu_req = 1'b1; mdu_addr = 5'd7; mdu_data = 32'h2;
    cyc();
    chk_rf("coll_wb", 1'b1, 5'd7, 32'h1, 1'b0);
    wb_req = 1'b0;
    cyc();
    chk_rf("coll_mdu", 1'b1, 5'd7, 32'h2, 1'b1);
    mdu_req = 1'b0;
    cyc();
    check("coll_regs_r7", regs[7], 32'h2);

`ifdef RF_WPORT_REG_CLEAR_EN
    // Reset mid-clear at index 10 restarts from r1
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 1; i <= 10; i++) cyc();
    check("midclr_addr10", 32'(rf_waddr), 32'd10);
    rst = 1'b1; cyc();
    check("midclr_rst_wr", 32'(rf_wr), 32'd0);
    check("midclr_rst_busy", 32'(busy), 32'd1);
    rst = 1'b0; cyc();
    chk_rf("midclr_restart", 1'b1, 5'd1, 32'd0, 1'b0);
    for (int i = 2; i <= 32; i++) cyc();
    check("midclr_done", 32'(busy), 32'd0);
`endif

    // Reset with an MDU request pending behind WB: no ack
    wb_req = 1'b1; wb_addr = 5'd12; wb_data = 32'h3;
    mdu_req = 1'b1; mdu_addr = 5'd13; mdu_data = 32'h4;
    rst = 1'b1;
    cyc();
    chk_rf("rst_pend", 1'b0, 5'd0, 32'd0, 1'b0);
    check("rst_pend_waddr", 32'(rf_waddr), 32'd0);
    wb_req = 1'b0; mdu_req = 1'b0; rst = 1'b0;
    cyc();
    check("rst_pend_ack2", 32'(mdu_ack), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
